dcs_matmul: RTL and testbench
=============================

DCS_MATMUL -- requirements
Module: dcs_matmul

Interface
REQ-001 SHALL expose parameter N, default 4, matrix dimension (N x N operands), N in 2..8.
REQ-002 SHALL expose parameter DW, default 8, width of each i_data/w_data element.
REQ-003 SHALL expose parameter ACC_W, default 32, output width; legal only if ACC_W >= 2*DW + clog2(N).
REQ-004 SHALL expose parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL expose parameter RELU, default 0; 1 = clamp negative results to 0 (meaningful only when SIGNED=1).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port w_valid  input  1  weight element valid.
REQ-009 SHALL have port w_data  input  DW  weight element, W row-major.
REQ-010 SHALL have port w_ready  output  1  block accepts weight elements.
REQ-011 SHALL have port i_valid  input  1  input element valid.
REQ-012 SHALL have port i_data  input  DW  input element, X row-major.
REQ-013 SHALL have port o_valid  output  1  o_data holds a result element.
REQ-014 SHALL have port o_data  output  ACC_W  result element of Y = X*W, row-major.

Function
REQ-015 SHALL implement states IDLE, LOAD_W, WAIT_I, LOAD_I, OUTPUT.
REQ-016 w_ready SHALL be 1 in IDLE, LOAD_W and WAIT_I, and 0 in LOAD_I and OUTPUT.
REQ-017 Weight beat accepted when w_valid && w_ready; IDLE/WAIT_I -> LOAD_W on first beat; gaps in w_valid allowed; counts accepted beats only.
REQ-018 After the N*N-th accepted weight beat, state SHALL go to WAIT_I next cycle.
REQ-019 Input beat accepted when i_valid in WAIT_I or LOAD_I; first beat moves WAIT_I -> LOAD_I; gaps allowed.
REQ-020 i_valid in IDLE, LOAD_W or OUTPUT SHALL be ignored.
REQ-021 w_valid and i_valid both high in WAIT_I: weight beat SHALL win, i_data dropped, state -> LOAD_W (weight reload).
REQ-022 w_valid in LOAD_I SHALL be ignored.
REQ-023 After N*N-th accepted input beat, state -> OUTPUT; o_valid SHALL rise the following cycle (latency 1 clock after last input acceptance).
REQ-024 OUTPUT SHALL assert o_valid for exactly N*N consecutive cycles, one Y element per cycle, row-major Y[0][0]..Y[N-1][N-1], then o_valid low and state -> WAIT_I.
REQ-025 Y[i][j] SHALL equal sum over k of X[i][k]*W[k][j]; operands sign- or zero-extended per SIGNED; sum wraps modulo 2^ACC_W.
REQ-026 With RELU=1 and SIGNED=1, a result with MSB set SHALL be output as 0.
REQ-027 Weights SHALL persist across input batches until reloaded or reset.
REQ-028 o_data SHALL be registered and hold 0 whenever o_valid is 0.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, all counters 0, o_valid 0, o_data 0, w_ready 1 (IDLE), and mark weights invalid.
REQ-030 Reset mid-LOAD_W, mid-LOAD_I or mid-OUTPUT SHALL abort the operation; no further o_valid until a full weight load and input batch complete.

Structure
REQ-031 State enum and a helper function for minimum ACC_W SHALL live in shared package dcs_pkg.
REQ-032 One sub-module dcs_dot (N-term DW x DW dot product, parameterised N/DW/ACC_W/SIGNED) SHALL compute one Y element combinationally from buffered row and column.
REQ-033 Counters SHALL be clog2(N*N)+1 bits wide.

Verification
REQ-034 N=4, W=identity, X=1..16 -> o_valid 16 cycles, o_data 1..16, first o_valid 1 cycle after 16th input beat.
REQ-035 SIGNED=1, W all 0xFF (-1), X all 2 -> all 16 outputs 0xFFFFFFF8; same with RELU=1 -> all 0.
REQ-036 Weight reuse: one load of W=identity, two batches X=1..16 then X=16..1 with random i_valid gaps -> outputs equal X each batch, no w beats needed.
REQ-037 In WAIT_I drive w_valid and i_valid same cycle with new W = 2*identity -> w_ready accepts, input dropped; subsequent batch X=1..16 -> outputs 2,4,..,32.
REQ-038 Assert rst_n low during 5th OUTPUT cycle -> o_valid/o_data 0 immediately, w_ready 1; i_valid without new weights -> no o_valid.

Source files
------------

// File: rtl/dcs_pkg.sv
// rtl/dcs_pkg.sv - shared types and helpers for the dcs_matmul block
// Purpose: FSM state encoding and the minimum legal accumulator width.
// Ports: none (package).
package dcs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    WAIT_I,
    LOAD_I,
    OUTPUT
  } state_t;

  // Smallest accumulator that holds an N-term sum of DW x DW products.
  function automatic int min_acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/dcs_dot.sv
// rtl/dcs_dot.sv - combinational N-term dot product
// Purpose: y = sum over k of a[k]*b[k], operands sign- or zero-extended,
//          result wraps modulo 2^ACC_W.
// Ports:
//   a : input  N x DW  row operand
//   b : input  N x DW  column operand
//   y : output ACC_W   dot product
module dcs_dot #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic [N-1:0][DW-1:0] a,
  input  logic [N-1:0][DW-1:0] b,
  output logic [ACC_W-1:0]     y
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] acc;

  // Extending both factors to ACC_W before multiplying gives the correct
  // two's-complement product modulo 2^ACC_W for signed operands.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    acc   = '0;
    for (int k = 0; k < N; k++) begin
      a_ext = {{(ACC_W-DW){(SIGNED != 0) && a[k][DW-1]}}, a[k]};
      b_ext = {{(ACC_W-DW){(SIGNED != 0) && b[k][DW-1]}}, b[k]};
      acc   = acc + a_ext * b_ext;
    end
    y = acc;
  end

endmodule

// File: rtl/dcs_matmul.sv
// rtl/dcs_matmul.sv - streaming N x N matrix multiply Y = X * W
// Purpose: loads W and X row-major as element streams, then emits Y
//          row-major, one element per cycle. W persists across batches.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   w_valid, w_data  : weight element stream (W row-major)
//   w_ready          : weight element accepted when high
//   i_valid, i_data  : input element stream (X row-major)
//   o_valid, o_data  : registered result stream (Y row-major), 0 when idle
module dcs_matmul
  import dcs_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1,
  parameter int RELU   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_valid,
  input  logic [DW-1:0]    w_data,
  output logic             w_ready,
  input  logic             i_valid,
  input  logic [DW-1:0]    i_data,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_data
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(NN) + 1;

  if (ACC_W < min_acc_w(N, DW)) begin : g_acc_w_check
    $error("dcs_matmul: ACC_W too small for N and DW");
  end

  state_t          state, state_nx;
  logic [CW-1:0]   w_cnt, i_cnt, o_cnt;
  logic [CW-1:0]   w_idx, i_idx;
  logic            w_ok;
  logic            w_acc, i_acc;
  logic [DW-1:0]   w_buf [NN];
  logic [DW-1:0]   x_buf [NN];
  logic [N-1:0][DW-1:0] row_v, col_v;
  logic [ACC_W-1:0] dot_y, y_out;

  always_comb begin
    w_ready  = (state == IDLE) || (state == LOAD_W) || (state == WAIT_I);
    w_acc    = w_valid && w_ready;
    // A weight beat in WAIT_I wins over a simultaneous input beat.
    i_acc    = i_valid && w_ok && !w_acc && ((state == WAIT_I) || (state == LOAD_I));
    // The first beat of a load always lands at index 0.
    w_idx    = (state == LOAD_W) ? w_cnt : '0;
    i_idx    = (state == LOAD_I) ? i_cnt : '0;
    state_nx = state;
    if (w_acc)
      state_nx = (w_idx == CW'(NN - 1)) ? WAIT_I : LOAD_W;
    else if (i_acc)
      state_nx = (i_idx == CW'(NN - 1)) ? OUTPUT : LOAD_I;
    else if ((state == OUTPUT) && (o_cnt == CW'(NN - 1)))
      state_nx = WAIT_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      w_cnt   <= '0;
      i_cnt   <= '0;
      o_cnt   <= '0;
      w_ok    <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      state <= state_nx;
      if (w_acc) begin
        w_cnt <= w_idx + CW'(1);
        // A reload invalidates the old matrix until the last beat lands.
        w_ok  <= (w_idx == CW'(NN - 1));
      end
      if (i_acc) begin
        i_cnt <= i_idx + CW'(1);
        o_cnt <= '0;
      end
      if (state == OUTPUT)
        o_cnt <= (o_cnt == CW'(NN - 1)) ? '0 : o_cnt + CW'(1);
      o_valid <= (state == OUTPUT);
      o_data  <= (state == OUTPUT) ? y_out : '0;
    end
  end

  // Matrix storage needs no reset; w_ok guards its validity.
  always_ff @(posedge clk) begin
    if (w_acc) w_buf[w_idx[IW-1:0]] <= w_data;
    if (i_acc) x_buf[i_idx[IW-1:0]] <= i_data;
  end

  // o_cnt walks Y row-major: row = o_cnt / N, column = o_cnt % N.
  always_comb begin
    row_v = '0;
    col_v = '0;
    for (int k = 0; k < N; k++) begin
      row_v[k] = x_buf[IW'((int'(o_cnt) / N) * N + k)];
      col_v[k] = w_buf[IW'(k * N + int'(o_cnt) % N)];
    end
  end

  dcs_dot #(
    .N      (N),
    .DW     (DW),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_dot (
    .a (row_v),
    .b (col_v),
    .y (dot_y)
  );

  assign y_out = ((RELU != 0) && (SIGNED != 0) && dot_y[ACC_W-1]) ? '0 : dot_y;

endmodule

// File: tb/tb_dcs_matmul.sv
// tb/tb_dcs_matmul.sv - scoreboard bench for dcs_matmul (plain and ReLU instances)
module tb_dcs_matmul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_valid = 1'b0;
  logic [7:0]  w_data = '0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        w_ready, w_ready_r;
  logic        o_valid, o_valid_r;
  logic [31:0] o_data, o_data_r;

  dcs_matmul #(.N(4), .DW(8), .ACC_W(32), .SIGNED(1), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid), .o_data(o_data));

  dcs_matmul #(.N(4), .DW(8), .ACC_W(32), .SIGNED(1), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready_r),
    .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid_r), .o_data(o_data_r));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_in_cyc = 0;
  int out_seen = 0;
  int burst = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic signed [7:0] wm [16];
  logic signed [7:0] xm [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      burst = 0;
    end else begin
      chk(o_valid_r == o_valid, "relu_valid_align", 32'(o_valid_r), 32'(o_valid));
      if (o_valid) begin
        if (burst == 0) chk(cyc == last_in_cyc + 1, "first_out_latency", cyc, last_in_cyc + 1);
        burst++;
        out_seen++;
        if (q0.size() == 0) chk(1'b0, "unexpected_o_valid", o_data, 32'hx);
        else begin
          e = q0.pop_front();
          chk(o_data == e, "o_data", o_data, e);
        end
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk(o_data_r == e, "o_data_relu", o_data_r, e);
        end
      end else begin
        if (burst != 0) chk(burst == 16, "burst_len", burst, 16);
        burst = 0;
        chk(o_data == 0, "idle_o_data_zero", o_data, 0);
        chk(o_data_r == 0, "idle_o_data_relu_zero", o_data_r, 0);
      end
    end
  end

  task automatic push_expected();
    int acc;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += int'(xm[i*4+k]) * int'(wm[k*4+j]);
        q0.push_back(32'(acc));
        q1.push_back((acc < 0) ? 32'd0 : 32'(acc));
      end
  endtask

  task automatic send_w(input bit coll, input bit gaps);
    for (int e = 0; e < 16; e++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk); w_valid = 1'b0; i_valid = 1'b0;
      end
      @(negedge clk);
      w_valid = 1'b1;
      w_data  = wm[e];
      i_valid = 1'b0;
      if (coll && e == 0) begin
        i_valid = 1'b1;
        i_data  = 8'h55;
        chk(w_ready == 1'b1, "collide_w_ready", 32'(w_ready), 1);
      end
      @(posedge clk);
    end
    @(negedge clk);
    w_valid = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic send_x(input bit gaps, input bit push);
    for (int e = 0; e < 16; e++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk); i_valid = 1'b0;
      end
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = xm[e];
      @(posedge clk);
    end
    @(negedge clk);
    i_valid = 1'b0;
    if (push) begin
      last_in_cyc = cyc;
      push_expected();
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || o_valid) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk(n < 200, name, n, 200);
  endtask

  initial begin
    int n;
    int seen;
    repeat (3) @(negedge clk);
    chk(o_valid == 1'b0, "reset_o_valid", 32'(o_valid), 0);
    chk(o_data == 0, "reset_o_data", o_data, 0);
    chk(w_ready == 1'b1, "reset_w_ready", 32'(w_ready), 1);
    rst_n = 1'b1;

    // Inputs before any weights must be ignored.
    repeat (4) begin @(negedge clk); i_valid = 1'b1; i_data = 8'h11; end
    @(negedge clk); i_valid = 1'b0;
    chk(w_ready == 1'b1, "idle_inputs_ignored", 32'(w_ready), 1);

    // W = identity, X = 1..16.
    for (int e = 0; e < 16; e++) begin
      wm[e] = (e / 4 == e % 4) ? 8'sd1 : 8'sd0;
      xm[e] = 8'(e + 1);
    end
    send_w(1'b0, 1'b0);
    send_x(1'b0, 1'b1);
    wait_done("identity_done");

    // Weight reuse with gapped input batches.
    send_x(1'b1, 1'b1);
    wait_done("reuse_fwd_done");
    for (int e = 0; e < 16; e++) xm[e] = 8'(16 - e);
    send_x(1'b1, 1'b1);
    wait_done("reuse_rev_done");

    // Collision in WAIT_I: weight wins, W reloads to 2*identity.
    for (int e = 0; e < 16; e++) begin
      wm[e] = (e / 4 == e % 4) ? 8'sd2 : 8'sd0;
      xm[e] = 8'(e + 1);
    end
    send_w(1'b1, 1'b1);
    send_x(1'b0, 1'b1);
    wait_done("reload_2i_done");

    // Signed: W = -1, X = 2 -> -8 each; ReLU instance gives 0.
    for (int e = 0; e < 16; e++) begin
      wm[e] = -8'sd1;
      xm[e] = 8'sd2;
    end
    send_w(1'b0, 1'b0);
    send_x(1'b0, 1'b1);
    chk(q0[0] == 32'hFFFF_FFF8, "signed_expect", q0[0], 32'hFFFF_FFF8);
    wait_done("signed_done");

    // Reset during the 5th output cycle.
    for (int e = 0; e < 16; e++) xm[e] = 8'(e + 1);
    seen = out_seen;
    send_x(1'b0, 1'b1);
    n = 0;
    while (out_seen < seen + 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk(n < 100, "reach_5th_output", n, 100);
    #2 rst_n = 1'b0;
    #1;
    chk(o_valid == 1'b0, "async_reset_o_valid", 32'(o_valid), 0);
    chk(o_data == 0, "async_reset_o_data", o_data, 0);
    chk(w_ready == 1'b1, "async_reset_w_ready", 32'(w_ready), 1);
    chk(w_ready_r == 1'b1, "async_reset_w_ready_relu", 32'(w_ready_r), 1);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    send_x(1'b0, 1'b0);
    n = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (o_valid || o_valid_r) n++;
    end
    chk(n == 0, "no_output_after_reset", n, 0);
    chk(w_ready == 1'b1, "post_reset_w_ready", 32'(w_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
